// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 16-bit 5-stage core: EX forwarding selects,
// load-use stall, branch flush and data-memory freeze. Optional macro: HAZARD_PERF_CNT_EN.
module hazard_fwd_ctrl #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_access,
    input  logic              mem_ready,
    input  logic              ex_branch_taken,
    output logic [1:0]        arg1_sel,
    output logic [1:0]        arg2_sel,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] SEL_MEM = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_RF  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LD_STALL = 2'd2
    } stateT;

    stateT state;
    stateT nextState;

    logic memWait;
    logic loadUse;
    logic branchNow;
    logic stallNow;

    assign memWait   = mem_access && !mem_ready;
    assign loadUse   = ex_memread && ex_regwrite && (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));
    assign branchNow = ex_branch_taken && !memWait;
    // The stall cycle is the detection cycle; LD_STALL marks it so it cannot repeat.
    assign stallNow  = loadUse && !memWait && !ex_branch_taken && (state != LD_STALL);

    function automatic logic [1:0] fwdSel(
        input logic              useReg,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] exRd,
        input logic              exRegWrite,
        input logic [REG_AW-1:0] memRd,
        input logic              memRegWrite
    );
        if (!useReg || (rs == '0)) begin
            return SEL_RF;
        end else if (exRegWrite && (exRd == rs)) begin
            return SEL_MEM;
        end else if (memRegWrite && (memRd == rs)) begin
            return SEL_WB;
        end
        return SEL_RF;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = RUN;
        if (memWait) begin
            nextState = MEM_WAIT;
        end else if (branchNow) begin
            nextState = RUN;
        end else if (stallNow) begin
            nextState = LD_STALL;
        end
    end

    // Priority: reset, memory wait, branch flush, load-use stall.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (memWait) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (branchNow) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stallNow) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            arg1_sel <= SEL_RF;
            arg2_sel <= SEL_RF;
        end else if (pipe_freeze) begin
            arg1_sel <= arg1_sel;
            arg2_sel <= arg2_sel;
        end else if (idex_bubble) begin
            arg1_sel <= SEL_RF;
            arg2_sel <= SEL_RF;
        end else begin
            arg1_sel <= fwdSel(id_use_rs1, id_rs1, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
            arg2_sel <= fwdSel(id_use_rs2, id_rs2, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!pc_write && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (ifid_flush && (flushCnt != '1)) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stallCnt;
    assign flush_cnt = flushCnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl: inputs change on the falling edge,
// combinational controls and registered selects are sampled 1 ns later.
module tb_hazard_fwd_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  id_rs1;
    logic [2:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [2:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [2:0]  mem_rd;
    logic        mem_regwrite;
    logic        mem_access;
    logic        mem_ready;
    logic        ex_branch_taken;
    logic [1:0]  arg1_sel;
    logic [1:0]  arg2_sel;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_freeze;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checkCount = 0;
    int errorCount = 0;

    hazard_fwd_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread),
        .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite),
        .mem_access(mem_access),
        .mem_ready(mem_ready),
        .ex_branch_taken(ex_branch_taken),
        .arg1_sel(arg1_sel),
        .arg2_sel(arg2_sel),
        .pc_write(pc_write),
        .ifid_write(ifid_write),
        .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble),
        .pipe_freeze(pipe_freeze),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic pc, input logic ifid,
                             input logic flush, input logic bubble, input logic freeze);
        checkOutput({tag, ".pc_write"}, 32'(pc_write), 32'(pc));
        checkOutput({tag, ".ifid_write"}, 32'(ifid_write), 32'(ifid));
        checkOutput({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(flush));
        checkOutput({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bubble));
        checkOutput({tag, ".pipe_freeze"}, 32'(pipe_freeze), 32'(freeze));
    endtask

    task automatic checkSel(input string tag, input logic [1:0] a1, input logic [1:0] a2);
        checkOutput({tag, ".arg1_sel"}, 32'(arg1_sel), 32'(a1));
        checkOutput({tag, ".arg2_sel"}, 32'(arg2_sel), 32'(a2));
    endtask

    task automatic applyStimulus(input logic rstN, input logic [2:0] rs1, input logic [2:0] rs2,
                                 input logic use1, input logic use2,
                                 input logic [2:0] exRd, input logic exRw, input logic exMr,
                                 input logic [2:0] memRd, input logic memRw,
                                 input logic memAcc, input logic memRdy, input logic br);
        @(negedge clk);
        reset           = rstN;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_use_rs1      = use1;
        id_use_rs2      = use2;
        ex_rd           = exRd;
        ex_regwrite     = exRw;
        ex_memread      = exMr;
        mem_rd          = memRd;
        mem_regwrite    = memRw;
        mem_access      = memAcc;
        mem_ready       = memRdy;
        ex_branch_taken = br;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; mem_access = 1'b0; mem_ready = 1'b1;
        ex_branch_taken = 1'b0;

        applyStimulus(0, 0,0,0,0, 0,0,0, 0,0, 0,1, 0);
        applyStimulus(0, 0,0,0,0, 0,0,0, 0,0, 0,1, 0);
        checkCtrl("reset", 0,0,0,1,0);
        checkSel("reset", 2'b10, 2'b10);
        checkOutput("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("reset.flush_cnt", 32'(flush_cnt), 32'd0);

        // ld r2 in EX, add r3,r2,r1 in ID: one stall cycle, then WB forward of r2
        applyStimulus(1, 2,1,1,1, 2,1,1, 0,0, 0,1, 0);
        checkCtrl("ldUse", 0,0,0,1,0);
        applyStimulus(1, 2,1,1,1, 0,0,0, 2,1, 0,1, 0);
        checkSel("ldBubble", 2'b10, 2'b10);
        checkCtrl("ldResume", 1,1,0,0,0);
        applyStimulus(1, 0,0,0,0, 0,0,0, 0,0, 0,1, 0);
        checkSel("ldFwd", 2'b01, 2'b10);

        // add r2 in EX, sub r4,r2,r2 in ID: no stall, both from MEM
        applyStimulus(1, 2,2,1,1, 2,1,0, 0,0, 0,1, 0);
        checkCtrl("aluNoStall", 1,1,0,0,0);
        applyStimulus(1, 5,0,1,1, 5,1,0, 5,1, 0,1, 0);
        checkSel("aluFwd", 2'b00, 2'b00);
        applyStimulus(1, 0,3,1,1, 0,1,0, 3,1, 0,1, 0);
        checkSel("exOverMem", 2'b00, 2'b10);
        applyStimulus(1, 4,4,0,1, 4,1,0, 0,0, 0,1, 0);
        checkSel("zeroReg", 2'b10, 2'b01);
        applyStimulus(1, 6,7,1,1, 6,1,0, 7,1, 0,1, 0);
        checkSel("noUse", 2'b10, 2'b00);

        // three wait cycles: freeze, selects hold the 00/01 loaded above
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 2,2,1,1, 2,1,0, 0,0, 1,0, 0);
            checkCtrl("memWait", 0,0,0,0,1);
            checkSel("memHold", 2'b00, 2'b01);
        end
        applyStimulus(1, 3,3,1,1, 0,0,0, 3,1, 1,1, 0);
        checkCtrl("memExit", 1,1,0,0,0);
        checkSel("memHoldExit", 2'b00, 2'b01);

        // branch together with load-use: flush wins and no LD_STALL is entered
        applyStimulus(1, 2,1,1,1, 2,1,1, 0,0, 0,1, 1);
        checkSel("exitFwd", 2'b01, 2'b01);
        checkCtrl("brOverLd", 1,1,1,1,0);
        applyStimulus(1, 2,1,1,1, 2,1,1, 0,0, 0,1, 0);
        checkSel("brBubble", 2'b10, 2'b10);
        checkCtrl("brNoLdState", 0,0,0,1,0);
        applyStimulus(1, 0,0,0,0, 0,0,0, 0,0, 0,1, 0);
        checkCtrl("afterStall", 1,1,0,0,0);

        // branch held through a memory wait is taken on the exit cycle
        applyStimulus(1, 0,0,0,0, 0,0,0, 0,0, 1,0, 1);
        checkCtrl("brInWait", 0,0,0,0,1);
        applyStimulus(1, 0,0,0,0, 0,0,0, 0,0, 1,1, 1);
        checkCtrl("brOnExit", 1,1,1,1,0);

        // reset asserted during MEM_WAIT
        applyStimulus(1, 6,7,1,1, 6,1,0, 7,1, 0,1, 0);
        applyStimulus(1, 0,0,0,0, 0,0,0, 0,0, 1,0, 0);
        checkSel("preRst", 2'b00, 2'b01);
        checkCtrl("preRst", 0,0,0,0,1);
        applyStimulus(0, 0,0,0,0, 0,0,0, 0,0, 1,0, 0);
        checkCtrl("rstInWait", 0,0,0,1,0);
        applyStimulus(1, 0,0,0,0, 0,0,0, 0,0, 0,1, 0);
        checkSel("rstSel", 2'b10, 2'b10);
        checkCtrl("rstRun", 1,1,0,0,0);
        checkOutput("rstRun.stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("rstRun.flush_cnt", 32'(flush_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
